// File: rtl/pc_seq_pkg.sv
// Shared select encoding and default geometry for the program-counter sequencer.
package pc_seq_pkg;

   localparam int unsigned PC_WIDTH_DEF        = 16;
   localparam int unsigned PC_STEP_DEF         = 1;
   localparam int unsigned PC_RESET_VECTOR_DEF = 0;
   localparam int unsigned PC_RAS_DEPTH_DEF    = 4;

   typedef enum logic [2:0] {
      SEL_HOLD,
      SEL_SEQ,
      SEL_BRANCH,
      SEL_CALL,
      SEL_RET
   } pc_sel_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the control unit (master) and the PC sequencer (slave).
interface pc_sequencer_if
   import pc_seq_pkg::*;
#(
   parameter int unsigned WIDTH = PC_WIDTH_DEF
);

   logic             stall;
   logic             branch_en;
   logic [WIDTH-1:0] branch_target;
   logic             call_en;
   logic             ret_en;
   logic             err_clr;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] pc_seq;
   logic             ras_empty;
   logic             ras_full;
   logic             ras_ovf;
   logic             ras_unf;

   modport master (
      output stall, branch_en, branch_target, call_en, ret_en, err_clr,
      input  pc, pc_seq, ras_empty, ras_full, ras_ovf, ras_unf
   );

   modport slave (
      input  stall, branch_en, branch_target, call_en, ret_en, err_clr,
      output pc, pc_seq, ras_empty, ras_full, ras_ovf, ras_unf
   );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: pushing when full overwrites the oldest entry.
module pc_ras
   import pc_seq_pkg::*;
#(
   parameter int unsigned WIDTH     = PC_WIDTH_DEF,
   parameter int unsigned RAS_DEPTH = PC_RAS_DEPTH_DEF
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic [WIDTH-1:0]             push_data_i,
   output logic [WIDTH-1:0]             top_o,
   output logic [$clog2(RAS_DEPTH):0]   count_o,
   output logic                         full_o,
   output logic                         empty_o
);

   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [RAS_DEPTH];
   logic [PTR_W-1:0] wp_q, wp_d, top_idx;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // wp_q is the next free slot; the newest entry sits just below it.
   assign top_idx = wp_q - PTR_W'(1);
   assign top_o   = mem_q[top_idx];
   assign count_o = cnt_q;
   assign full_o  = (cnt_q == CNT_W'(RAS_DEPTH));
   assign empty_o = (cnt_q == '0);

   always_comb begin
      wp_d  = wp_q;
      cnt_d = cnt_q;
      if (push_i) begin
         wp_d = wp_q + PTR_W'(1);
         if (!full_o) cnt_d = cnt_q + CNT_W'(1);
      end else if (pop_i && !empty_o) begin
         wp_d  = top_idx;
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_q  <= '0;
         cnt_q <= '0;
      end else begin
         wp_q  <= wp_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wp_q] <= push_data_i;
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: prioritised next-PC select, PC register, sticky RAS error flags.
// The return-address stack and call/return semantics are built only when PC_SEQ_RAS_EN is defined.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int unsigned WIDTH        = PC_WIDTH_DEF,
   parameter int unsigned STEP         = PC_STEP_DEF,
   parameter int unsigned RESET_VECTOR = PC_RESET_VECTOR_DEF,
   parameter int unsigned RAS_DEPTH    = PC_RAS_DEPTH_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   pc_sequencer_if.slave bus
);

   pc_sel_e          sel;
   logic [WIDTH-1:0] pc_q, pc_d, pc_seq_w, ras_top_w;
   logic             ras_empty_w;

   assign pc_seq_w = pc_q + WIDTH'(STEP);

   always_comb begin
      sel = SEL_SEQ;
      if (bus.stall)          sel = SEL_HOLD;
`ifdef PC_SEQ_RAS_EN
      else if (bus.ret_en)    sel = SEL_RET;
      else if (bus.call_en)   sel = SEL_CALL;
`else
      // Without a stack, ret still outranks call but degrades to a plain increment.
      else if (bus.ret_en)    sel = SEL_SEQ;
      else if (bus.call_en)   sel = SEL_BRANCH;
`endif
      else if (bus.branch_en) sel = SEL_BRANCH;
   end

   always_comb begin
      pc_d = pc_seq_w;
      unique case (sel)
         SEL_HOLD:             pc_d = pc_q;
         SEL_BRANCH, SEL_CALL: pc_d = bus.branch_target;
         SEL_RET:              pc_d = ras_empty_w ? pc_seq_w : ras_top_w;
         default:              pc_d = pc_seq_w;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_q <= WIDTH'(RESET_VECTOR);
      else        pc_q <= pc_d;
   end

   assign bus.pc     = pc_q;
   assign bus.pc_seq = pc_seq_w;

`ifdef PC_SEQ_RAS_EN
   logic                       ras_full_w;
   logic                       ovf_q, ovf_d, unf_q, unf_d;
   logic [$clog2(RAS_DEPTH):0] unused_ras_count;

   pc_ras #(
      .WIDTH     (WIDTH),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (sel == SEL_CALL),
      .pop_i       (sel == SEL_RET),
      .push_data_i (pc_seq_w),
      .top_o       (ras_top_w),
      .count_o     (unused_ras_count),
      .full_o      (ras_full_w),
      .empty_o     (ras_empty_w)
   );

   // Clear first so that an error raised in the same cycle survives the clear.
   always_comb begin
      ovf_d = ovf_q;
      unf_d = unf_q;
      if (bus.err_clr) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end
      if (sel == SEL_CALL && ras_full_w)  ovf_d = 1'b1;
      if (sel == SEL_RET  && ras_empty_w) unf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign bus.ras_empty = ras_empty_w;
   assign bus.ras_full  = ras_full_w;
   assign bus.ras_ovf   = ovf_q;
   assign bus.ras_unf   = unf_q;
`else
   logic unused_err_clr;

   // RAS_DEPTH is at least two, so the stack always reads as empty here.
   assign ras_empty_w    = (RAS_DEPTH > 1);
   assign ras_top_w      = '0;
   assign unused_err_clr = bus.err_clr;

   assign bus.ras_empty = ras_empty_w;
   assign bus.ras_full  = 1'b0;
   assign bus.ras_ovf   = 1'b0;
   assign bus.ras_unf   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: queue-based reference model plus directed literal checks.
module tb_pc_sequencer;

   localparam int unsigned W     = 16;
   localparam int unsigned STEP  = 1;
   localparam int unsigned RV    = 0;
   localparam int unsigned DEPTH = 4;
`ifdef PC_SEQ_RAS_EN
   localparam bit RAS_EN = 1'b1;
`else
   localparam bit RAS_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   pc_sequencer_if #(.WIDTH(W)) bus ();

   pc_sequencer #(
      .WIDTH        (W),
      .STEP         (STEP),
      .RESET_VECTOR (RV),
      .RAS_DEPTH    (DEPTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [W-1:0] m_pc;
   logic [W-1:0] m_stk[$];
   bit           m_ovf, m_unf;
   int           n_cmp  = 0;
   int           n_fail = 0;

   function automatic void check(string name, logic [W-1:0] act, logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h, expected 0x%04h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic logic [W-1:0] pick(logic [W-1:0] with_ras, logic [W-1:0] without_ras);
      return RAS_EN ? with_ras : without_ras;
   endfunction

   task automatic model_reset();
      m_pc = W'(RV);
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   // One clock of architectural behaviour, written from the select priority rules.
   task automatic model_step();
      logic [W-1:0] seq;
      bit set_o, set_u;
      seq   = m_pc + W'(STEP);
      set_o = 1'b0;
      set_u = 1'b0;
      if (bus.stall) begin
      end else if (bus.ret_en) begin
         if (RAS_EN && m_stk.size() > 0) m_pc = m_stk.pop_back();
         else begin
            m_pc  = seq;
            set_u = RAS_EN;
         end
      end else if (bus.call_en) begin
         if (RAS_EN) begin
            m_stk.push_back(seq);
            if (m_stk.size() > DEPTH) begin
               void'(m_stk.pop_front());
               set_o = 1'b1;
            end
         end
         m_pc = bus.branch_target;
      end else if (bus.branch_en) begin
         m_pc = bus.branch_target;
      end else begin
         m_pc = seq;
      end
      if (bus.err_clr) begin
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end
      if (set_o) m_ovf = 1'b1;
      if (set_u) m_unf = 1'b1;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else        model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         check("pc",        bus.pc,             m_pc);
         check("pc_seq",    bus.pc_seq,         m_pc + W'(STEP));
         check("ras_empty", W'(bus.ras_empty),  W'(RAS_EN ? (m_stk.size() == 0) : 1'b1));
         check("ras_full",  W'(bus.ras_full),   W'(RAS_EN && (m_stk.size() == DEPTH)));
         check("ras_ovf",   W'(bus.ras_ovf),    W'(m_ovf));
         check("ras_unf",   W'(bus.ras_unf),    W'(m_unf));
      end
   end

   task automatic drive(bit st, bit br, bit ca, bit rt, bit clr, logic [W-1:0] tgt);
      bus.stall         = st;
      bus.branch_en     = br;
      bus.call_en       = ca;
      bus.ret_en        = rt;
      bus.err_clr       = clr;
      bus.branch_target = tgt;
      @(posedge clk);
      #2;
   endtask

   task automatic seq1();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.stall = 1'b0; bus.branch_en = 1'b0; bus.call_en = 1'b0;
      bus.ret_en = 1'b0; bus.err_clr = 1'b0; bus.branch_target = '0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      // Asynchronous reset from a non-reset PC, observed before any clock edge.
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0042);
      check("lit_branch_0042", bus.pc, 16'h0042);
      rst_n = 1'b0;
      #1;
      check("lit_rst_pc",    bus.pc,            16'h0000);
      check("lit_rst_empty", W'(bus.ras_empty), 16'h0001);
      check("lit_rst_full",  W'(bus.ras_full),  16'h0000);
      check("lit_rst_ovf",   W'(bus.ras_ovf),   16'h0000);
      check("lit_rst_unf",   W'(bus.ras_unf),   16'h0000);
      @(posedge clk);
      #2 rst_n = 1'b1;

      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF);
      seq1();
      check("lit_wrap_pc",  bus.pc,          16'h0000);
      check("lit_wrap_ovf", W'(bus.ras_ovf), 16'h0000);

      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234);
      check("lit_stall_hold", bus.pc, 16'h0000);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234);
      check("lit_branch_1234", bus.pc, 16'h1234);

      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010);
      seq1();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0100);
      check("lit_call1", bus.pc, 16'h0100);
      seq1();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0200);
      check("lit_call2", bus.pc, 16'h0200);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
      check("lit_ret1", bus.pc, pick(16'h0102, 16'h0201));
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
      check("lit_ret2", bus.pc, pick(16'h0012, 16'h0202));
      check("lit_nest_empty", W'(bus.ras_empty), 16'h0001);

      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0020);
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, W'(16'h0300 + i * 16'h0100));
         if (i == 3) check("lit_full4", W'(bus.ras_full), pick(16'h0001, 16'h0000));
      end
      check("lit_ovf", W'(bus.ras_ovf), pick(16'h0001, 16'h0000));
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
         check("lit_ovf_ret", bus.pc, pick(W'(16'h0601 - i * 16'h0100), W'(16'h0701 + i)));
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
      check("lit_unf_pc",  bus.pc,          pick(16'h0302, 16'h0705));
      check("lit_unf",     W'(bus.ras_unf), pick(16'h0001, 16'h0000));
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
      check("lit_clr_ovf", W'(bus.ras_ovf), 16'h0000);
      check("lit_clr_unf", W'(bus.ras_unf), 16'h0000);
      check("lit_clr_pc",  bus.pc,          pick(16'h0303, 16'h0706));

      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h004F);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0800);
      check("lit_prio_call", bus.pc, 16'h0800);
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0900);
      check("lit_prio_pc",    bus.pc,            pick(16'h0050, 16'h0801));
      check("lit_prio_empty", W'(bus.ras_empty), 16'h0001);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 399) == 0) begin
            rst_n = 1'b0;
            @(posedge clk);
            #2 rst_n = 1'b1;
         end
         drive($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 20,
               $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 25,
               $urandom_range(0, 99) < 8,
               ($urandom_range(0, 3) == 0) ? W'(16'hFFF0 + $urandom_range(0, 15)) : W'($urandom));
      end

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the processor datapath. Holds the PC register and forms the next PC every cycle: sequential increment by a configurable step, branch/jump load, stall hold, and call/return through a small hardware return-address stack (RAS). Sits at the front of the fetch stage, drives instruction-memory address, and takes its control inputs from the control unit.

## Interface
Parameters:
- WIDTH, 16, PC and address width in bits
- STEP, 1, sequential increment added to the PC each non-stalled cycle
- RESET_VECTOR, 0, PC value loaded on reset
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold PC and RAS this cycle
- branch_en  in  1  load branch_target into PC
- branch_target  in  WIDTH  branch/jump destination
- call_en  in  1  push return address, load branch_target into PC
- ret_en  in  1  pop RAS top into PC
- err_clr  in  1  clear sticky error flags
- pc  out  WIDTH  current PC (registered)
- pc_seq  out  WIDTH  pc + STEP (combinational)
- ras_empty  out  1  RAS holds no entries
- ras_full  out  1  RAS holds RAS_DEPTH entries
- ras_ovf  out  1  sticky: call issued while full
- ras_unf  out  1  sticky: ret issued while empty

## Operation
- Next-PC select, priority highest first: stall → HOLD; ret_en → RET; call_en → CALL; branch_en → BRANCH; else SEQ.
- HOLD: pc, RAS, flags unchanged (err_clr still honoured).
- SEQ: pc ← pc + STEP, modulo 2^WIDTH (wraps silently, no flag).
- BRANCH: pc ← branch_target.
- CALL: push pc_seq onto RAS; pc ← branch_target. If full: oldest entry overwritten (circular), depth stays RAS_DEPTH, ras_ovf set.
- RET, non-empty: pc ← RAS top; pop. RET, empty: pc ← pc_seq, RAS unchanged, ras_unf set.
- Lower-priority requests in the same cycle are dropped, not queued (call+ret → only ret).
- err_clr clears ras_ovf/ras_unf; a set event in the same cycle wins over clear.
- ras_empty/ras_full derived from registered entry count (0..RAS_DEPTH).

## Timing
- Reset (async, rst_n low): pc = RESET_VECTOR, RAS count 0, ras_empty = 1, ras_full = 0, ras_ovf = ras_unf = 0. Held while rst_n low; first update on first rising edge after deassertion.
- All state changes on rising clk; pc reflects decision one cycle after inputs sampled.
- pc_seq follows pc combinationally, zero latency.
- RET uses RAS top as held before the edge; pushed address visible for pop the cycle after CALL.
- Reset mid-call/ret: stack contents discarded, count returns to 0 immediately.

## Configuration
- PC_SEQ_RAS_EN defined: RAS, call/return behaviour and flags as above.
- Not defined: no stack storage; call_en behaves as branch_en (no push), ret_en behaves as SEQ, ras_empty tied 1, ras_full/ras_ovf/ras_unf tied 0. Ports remain present.

## Structure
- Package pc_seq_pkg: next-PC select enum (SEL_HOLD, SEL_SEQ, SEL_BRANCH, SEL_CALL, SEL_RET), default WIDTH/STEP/RESET_VECTOR constants.
- Sub-module pc_ras: circular LIFO (push, pop, top, count, full, empty), parametrised by WIDTH and RAS_DEPTH, instantiated only under PC_SEQ_RAS_EN.
- Top: priority select, PC register, adder, sticky flags.

## Test plan
- Reset: rst_n low mid-run with pc=0x0042 → pc=0x0000, ras_empty=1, flags 0 immediately, before any clk edge.
- Increment and wrap: WIDTH=16, STEP=1, pc=0xFFFF, no controls → next pc=0x0000, no flag.
- Branch and stall: branch_en, target 0x1234 with stall=1 → pc unchanged; stall=0 next cycle → pc=0x1234.
- Nested call/ret: pc=0x0010 call→0x0100; call→0x0200; ret → pc=0x0102; ret → pc=0x0012; ras_empty=1.
- Overflow/underflow: RAS_DEPTH=4, five calls → ras_ovf=1, four rets return newest four addresses; fifth ret → pc=pc+1, ras_unf=1; err_clr → both 0.
- Priority: call_en+ret_en+branch_en with one entry 0x0050 → pc=0x0050, count 0, no push.
